alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU.
- Adds WIDTH generalisation, XOR/shift ops, a multi-cycle shift-add multiplier, and full status flags (C, V, Z, N).
- Sits between an operand source and a result consumer.
- Both sides use valid/ready handshakes, so it can be dropped into a datapath pipeline.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2, power of two).
- SHW, $clog2(WIDTH), shift-amount bits taken from B (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  first operand
- b  input  WIDTH  second operand (shift amount = b[SHW-1:0] for shifts)
- op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  result
- c  output  1  carry flag
- v  output  1  signed-overflow flag
- z  output  1  s == 0
- n  output  1  s[WIDTH-1]

Behaviour:
- Reset (rst=1 at rising edge):
  - Forces state IDLE.
  - Clears out_valid, s, c, v, z and n to 0.
  - Overrides everything, including a mid-multiply operation, which is discarded.
- Handshake:
  - Transfer occurs on a cycle with valid && ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A single-cycle op may therefore be accepted in the same cycle the previous result drains.
  - out_valid stays high and s/c/v/z/n stay stable until out_ready is sampled high.
- FSM states: IDLE, MUL.
  - IDLE, accept with op≠MUL: compute combinationally and register into the output. out_valid=1 next cycle (latency 1).
  - IDLE, accept with op==MUL: latch a and b, clear the product accumulator and counter, go to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles.
    - After step WIDTH-1, write the result to the output and set out_valid. Latency from accept is WIDTH+1 cycles.
    - Return to IDLE.
    - in_ready=0 throughout MUL.
  - The output register is always empty when MUL finishes, because MUL is only entered when in_ready=1 and in_ready stays 0 during MUL.
  - If a result is accepted into IDLE while out_valid && !out_ready, nothing is accepted (in_ready=0); the registered output holds.
- Arithmetic (all WIDTH-bit, two's complement):
  - ADD: {c,s} = a+b. v = (a[msb]==b[msb]) && (s[msb]!=a[msb]).
  - SUB: {c,s} = a + ~b + 1. c=1 means no borrow. v = (a[msb]!=b[msb]) && (s[msb]!=a[msb]).
  - AND/OR/XOR: bitwise. c=0, v=0.
  - SHL: s = a << b[SHW-1:0]. c = last bit shifted out (0 if amount is 0). v=0.
  - SHR: logical right shift. c = last bit shifted out (0 if amount is 0). v=0.
  - MUL: unsigned. s = low WIDTH bits of a*b. c = (high WIDTH bits ≠ 0). v=0.
  - z and n are always derived from the final s, for every op.
- Boundaries:
  - Wrap-around on ADD/SUB is modular, with no saturation.
  - Shift amount uses only the low SHW bits of b; upper bits of b are ignored.
  - in_valid while in_ready=0 is ignored; the source must hold its request.
  - An op value is latched at accept; later changes to a, b or op do not affect the in-flight operation.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01, out_ready=1 -> one cycle later: s=0x80, c=0, v=1, z=0, n=1, out_valid=1.
- SUB a=0x05 b=0x05 -> s=0x00, c=1, v=0, z=1; then SUB a=0x00 b=0x01 -> s=0xFF, c=0, n=1.
- SHL a=0x81 b=0x01 -> s=0x02, c=1; SHR a=0x81 b=0x09 (amount 1) -> s=0x40, c=1; XOR 0xF0^0xFF -> 0x0F, c=0.
- MUL a=0x10 b=0x10 -> in_ready low for 8 cycles; out_valid exactly 9 cycles after accept with s=0x00, c=1, z=1. MUL 0x0C*0x0A -> s=0x78, c=0.
- Backpressure: out_ready=0 after an ADD result -> s and flags stable, in_ready=0; raise out_ready with a new in_valid in the same cycle -> new op accepted that cycle, new result the following cycle, no result lost or duplicated.
- Assert rst during MUL step 4 -> next cycle state IDLE, out_valid=0, s=0, in_ready=1; no stale product appears later.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops
// (add/sub/logic/shift) have latency 1; MUL runs a WIDTH-step shift-add
// multiplier and has latency WIDTH+1. Flags C, V, Z, N are registered with s.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             v_o,
    output logic             z_o,
    output logic             n_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpShl = 3'd5;
    localparam logic [2:0] OpShr = 3'd6;
    localparam logic [2:0] OpMul = 3'd7;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic                 c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

    logic                 accept;
    logic [WIDTH-1:0]     alu_s;
    logic                 alu_c, alu_v;
    logic [WIDTH:0]       wide;
    logic [SHW-1:0]       amt;
    logic [2*WIDTH-1:0]   acc_step;

    assign in_ready_o  = (state_q == StIdle) && (!out_valid_q || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = out_valid_q;
    assign s_o         = s_q;
    assign c_o         = c_q;
    assign v_o         = v_q;
    assign z_o         = z_q;
    assign n_o         = n_q;

    // Single-cycle datapath; shifts use a one-bit-wider vector so the last
    // bit shifted out lands in a fixed position (and is 0 for amount 0).
    always_comb begin
        alu_s = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        wide  = '0;
        amt   = b_i[SHW-1:0];
        case (op_i)
            OpAdd: begin
                wide  = {1'b0, a_i} + {1'b0, b_i};
                alu_s = wide[WIDTH-1:0];
                alu_c = wide[WIDTH];
                alu_v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (alu_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OpSub: begin
                wide  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
                alu_s = wide[WIDTH-1:0];
                alu_c = wide[WIDTH];
                alu_v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (alu_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OpAnd: alu_s = a_i & b_i;
            OpOr:  alu_s = a_i | b_i;
            OpXor: alu_s = a_i ^ b_i;
            OpShl: begin
                wide  = {1'b0, a_i} << amt;
                alu_s = wide[WIDTH-1:0];
                alu_c = wide[WIDTH];
            end
            OpShr: begin
                wide  = {a_i, 1'b0} >> amt;
                alu_s = wide[WIDTH:1];
                alu_c = wide[0];
            end
            default: ;
        endcase
    end

    // Partial product including the current multiplier bit.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state: handshake bookkeeping, op dispatch and multiplier steps.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        n_d         = n_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op_i == OpMul) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_i};
                        mplier_d = b_i;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        out_valid_d = 1'b1;
                        s_d         = alu_s;
                        c_d         = alu_c;
                        v_d         = alu_v;
                        z_d         = (alu_s == '0);
                        n_d         = alu_s[WIDTH-1];
                    end
                end
            end
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                // Output is guaranteed empty here: in_ready was 0 throughout.
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    s_d         = acc_step[WIDTH-1:0];
                    c_d         = (acc_step[2*WIDTH-1:WIDTH] != '0);
                    v_d         = 1'b0;
                    z_d         = (acc_step[WIDTH-1:0] == '0);
                    n_d         = acc_step[WIDTH-1];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset discards any multiply.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            c_q         <= c_d;
            v_q         <= v_d;
            z_q         <= z_d;
            n_q         <= n_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed vectors with literal expectations,
// plus a scoreboard fed by an arithmetic model that checks every output cycle.
module tb_alu_pipe;

    localparam int unsigned W = 8;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, s;
    logic [2:0]   op;
    logic         c, v, z, n;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] s;
        logic [3:0] f;   // {c, v, z, n}
        logic [2:0] op;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    logic front_seen = 1'b0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .op_i        (op),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .s_o         (s),
        .c_o         (c),
        .v_o         (v),
        .z_o         (z),
        .n_o         (n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {s, c, v, z, n} from plain integer arithmetic.
    function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x,
                                          input logic [7:0] y);
        int ux, uy, sx, sy, r, sr, k, rs;
        logic cf, vf;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y);
        k  = uy % W;
        cf = 1'b0; vf = 1'b0; rs = 0;
        case (o)
            ADD: begin
                r = ux + uy; rs = r % 256; cf = (r >= 256);
                sr = sx + sy; vf = (sr > 127) || (sr < -128);
            end
            SUB: begin
                r = ux - uy; rs = (r + 256) % 256; cf = (ux >= uy);
                sr = sx - sy; vf = (sr > 127) || (sr < -128);
            end
            AND_: rs = ux & uy;
            OR_:  rs = ux | uy;
            XOR_: rs = ux ^ uy;
            SHL: begin
                rs = (ux * (1 << k)) % 256;
                cf = (k == 0) ? 1'b0 : 1'(((ux >> (W - k)) & 1));
            end
            SHR: begin
                rs = ux >> k;
                cf = (k == 0) ? 1'b0 : 1'(((ux >> (k - 1)) & 1));
            end
            default: begin
                r = ux * uy; rs = r % 256; cf = (r >= 256);
            end
        endcase
        return {8'(rs), cf, vf, (rs == 0), (rs >= 128)};
    endfunction

    // Scoreboard: checks every valid output cycle (including held ones) and
    // records accepted ops; sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            front_seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    chk("sb_s", 32'(s), 32'(sb_q[0].s));
                    chk("sb_flags", 32'({c, v, z, n}), 32'(sb_q[0].f));
                    if (!front_seen) begin
                        chk("sb_latency", 32'(cyc - sb_q[0].cyc),
                            (sb_q[0].op == MUL) ? 32'd9 : 32'd1);
                        front_seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                logic [11:0] m;
                m = model(op, a, b);
                e.s = m[11:4]; e.f = m[3:0]; e.op = op; e.cyc = cyc;
                sb_q.push_back(e);
            end
        end
    end

    // Present one op and hold it until accepted; scramble inputs afterwards.
    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        logic rdy;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = x; b = y;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            if (i == 39) chk("accept_timeout", 32'd1, 32'd0);
        end
        #1;
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7));
        a  = 8'($urandom);
        b  = 8'($urandom);
    endtask

    // Wait for out_valid; returns number of falling edges waited, 0 on timeout.
    task automatic wait_out(output int cnt, output int zeros);
        cnt = 0; zeros = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt = i;
                break;
            end
            if (!in_ready) zeros++;
        end
        if (cnt == 0) chk("out_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] es, input logic [3:0] ef);
        int cnt, zeros;
        send(o, x, y);
        wait_out(cnt, zeros);
        chk({name, "_lat"}, 32'(cnt), (o == MUL) ? 32'd9 : 32'd1);
        chk({name, "_s"}, 32'(s), 32'(es));
        chk({name, "_cvzn"}, 32'({c, v, z, n}), 32'(ef));
        if (o == MUL) chk({name, "_busy"}, 32'(zeros), 32'd8);
    endtask

    initial begin
        int cnt, zeros, late;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = ADD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cvzn", 32'({c, v, z, n}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        //                  op    a      b      s      {c,v,z,n}
        run("add_ovf",  ADD,  8'h7F, 8'h01, 8'h80, 4'b0101);
        run("sub_zero", SUB,  8'h05, 8'h05, 8'h00, 4'b1010);
        run("sub_brw",  SUB,  8'h00, 8'h01, 8'hFF, 4'b0001);
        run("shl",      SHL,  8'h81, 8'h01, 8'h02, 4'b1000);
        run("shr_mask", SHR,  8'h81, 8'h09, 8'h40, 4'b1000);
        run("xor",      XOR_, 8'hF0, 8'hFF, 8'h0F, 4'b0000);
        run("shl_amt0", SHL,  8'h80, 8'h08, 8'h80, 4'b0001);
        run("shl_hi_b", SHL,  8'h01, 8'h0B, 8'h08, 4'b0000);
        run("and",      AND_, 8'hC3, 8'h5A, 8'h42, 4'b0000);
        run("add_wrap", ADD,  8'hFF, 8'h02, 8'h01, 4'b1000);
        run("sub_vneg", SUB,  8'h80, 8'h01, 8'h7F, 4'b1100);
        run("mul_ovf",  MUL,  8'h10, 8'h10, 8'h00, 4'b1010);
        run("mul",      MUL,  8'h0C, 8'h0A, 8'h78, 4'b0000);
        run("mul_ff",   MUL,  8'hFF, 8'hFF, 8'h01, 4'b1000);

        // Backpressure: hold an ADD result, offer a new op while stalled,
        // then release out_ready in the same cycle the new op is pending.
        @(posedge clk); #1;
        out_ready = 1'b0;
        run("bp_add", ADD, 8'h10, 8'h20, 8'h30, 4'b0000);
        @(posedge clk); #1;
        in_valid = 1'b1; op = OR_; a = 8'h0F; b = 8'hA0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_s", 32'(s), 32'h30);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(cnt, zeros);
        chk("bp_new_lat", 32'(cnt), 32'd1);
        chk("bp_new_s", 32'(s), 32'hAF);

        // Reset in the middle of a multiply.
        send(MUL, 8'h0C, 8'h0A);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_s", 32'(s), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        late = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) late++;
        end
        chk("mrst_no_stale", 32'(late), 32'd0);

        run("post_rst", ADD, 8'h01, 8'h01, 8'h02, 4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
